hazard3_dmi_apb_master: RTL and testbench
=========================================

Name: hazard3_dmi_apb_master

Overview:
- DTM-side DMI sequencer: accepts one DMI request at a time (op/addr/data) from the transport logic on a valid/ready interface.
- Runs each request as an APB master transfer and returns the DMI-style result (status/data) on a valid/ready response interface.
- Sits directly upstream of the APB async bridge, in the DTM clock domain, and drives the bridge's source APB port.
- Holds the DTM's sticky DMI error state, which the transport logic can query and clear.

Parameters:
- W_ADDR, 8, APB/DMI address width.
- W_DATA, 32, APB/DMI data width.

Ports:
- clk  in  1  DTM-domain clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high with req_valid.
- req_op  in  2  0=nop, 1=read, 2=write, 3=reserved.
- req_addr  in  W_ADDR  DMI address.
- req_data  in  W_DATA  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when high with rsp_valid.
- rsp_op  out  2  0=success, 2=failed.
- rsp_data  out  W_DATA  read data; 0 for any op other than a successful read.
- err_clr  in  1  clears err_sticky.
- err_sticky  out  1  sticky failure flag.
- dmi_psel  out  1  APB select.
- dmi_penable  out  1  APB enable.
- dmi_pwrite  out  1  APB write.
- dmi_paddr  out  W_ADDR  APB address.
- dmi_pwdata  out  W_DATA  APB write data.
- dmi_prdata  in  W_DATA  APB read data.
- dmi_pready  in  1  APB ready.
- dmi_pslverr  in  1  APB error.

Behaviour:
- Reset:
  - State IDLE.
  - dmi_psel, dmi_penable, dmi_pwrite, dmi_paddr, dmi_pwdata all 0.
  - rsp_valid, rsp_op, rsp_data, err_sticky all 0.
  - All outputs registered except req_ready.
- req_ready = (state == IDLE), combinational, independent of req_valid. Accept = req_valid & req_ready.
- IDLE, on accept:
  - op 1/2 with err_sticky=0: latch dmi_paddr=req_addr, dmi_pwdata=req_data (for a read, pwdata is loaded with req_data regardless of value), dmi_pwrite=(op==2). Assert dmi_psel=1, dmi_penable=0, go to SETUP.
  - op 1/2 with err_sticky=1: no bus access. Go to RESP with rsp_op=2, rsp_data=0.
  - op 0: no bus access. Go to RESP with rsp_op=0, rsp_data=0.
  - op 3: no bus access. Go to RESP with rsp_op=2, rsp_data=0; set err_sticky.
- SETUP (exactly one cycle): dmi_penable<=1, go to ACCESS.
- ACCESS: hold psel/penable/paddr/pwdata/pwrite stable until dmi_pready=1. On dmi_pready:
  - dmi_psel<=0, dmi_penable<=0.
  - rsp_op <= dmi_pslverr ? 2 : 0.
  - rsp_data <= (read && !dmi_pslverr) ? dmi_prdata : 0.
  - err_sticky <= 1 if dmi_pslverr.
  - Go to RESP.
- No timeout: ACCESS waits indefinitely for pready.
- RESP: rsp_valid=1. rsp_op/rsp_data held stable while rsp_ready=0. On rsp_ready: rsp_valid<=0, go to IDLE.
- dmi_paddr/pwdata/pwrite keep their last values outside a transfer; they change only on a bus-issuing accept.
- Latency with zero-wait APB (accept in cycle 0):
  - psel high in cycle 1; penable high in cycle 2.
  - pready sampled in cycle 2; rsp_valid high in cycle 3.
  - rsp_ready in cycle 3 → IDLE, req_ready high in cycle 4.
  - Peak throughput 1 transfer per 4 cycles. Each APB wait state adds 1 cycle.
- Bus-less ops (nop, op 3, or any op while sticky): rsp_valid high the cycle after accept.
- err_clr:
  - Clears err_sticky in any state.
  - A same-cycle set (pslverr on pready, or op 3 accept) wins over clear.
  - Does not alter a response already captured in RESP.
- err_sticky is sampled at accept only. A clear while a request is in flight affects the next request only.
- Reset mid-transfer: psel/penable deassert at the reset edge, with no response. rst is asserted together with the bridge's source-side reset; no completion is owed to the transport.
- Only APB SETUP→ACCESS ordering is generated. penable is never high without psel.

Test Plan:
- Write addr 0x10, data 0xdeadbeef, zero-wait APB → psel in cycle 1, penable in cycle 2, pwrite=1, rsp_valid in cycle 3 with rsp_op=0, rsp_data=0; req_ready low in cycles 1–3.
- Read addr 0x11, slave returns 0x12345678 after 3 wait states → penable held 4 cycles with addr stable; rsp_data=0x12345678, rsp_op=0.
- Write with dmi_pslverr=1 → rsp_op=2, err_sticky=1. Next read issues no psel and returns rsp_op=2. Pulse err_clr, then read → bus access, rsp_op=0.
- Nop, then op 3 → no psel either time. Nop gives rsp_op=0. Op 3 gives rsp_op=2 and err_sticky=1. Each response is valid the cycle after accept.
- Hold rsp_ready=0 for 5 cycles after a read of 0xa5a5a5a5 → rsp_valid, rsp_data stable; req_ready=0; no new psel until rsp_ready.
- Assert rst during ACCESS → next cycle psel=penable=0, rsp_valid=0, err_sticky=0, req_ready=1; a new request then completes normally.

Source files
------------

// File: rtl/hazard3_dmi_apb_master_if.sv
// DMI request/response, sticky-error control and source-side APB signals of the DMI sequencer.
// The DUT connects through modport master; the transport and the APB slave connect through modport slave.
interface hazard3_dmi_apb_master_if #(
  parameter int W_ADDR = 8,
  parameter int W_DATA = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [W_ADDR-1:0] req_addr;
  logic [W_DATA-1:0] req_data;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_op;
  logic [W_DATA-1:0] rsp_data;

  logic              err_clr;
  logic              err_sticky;

  logic              dmi_psel;
  logic              dmi_penable;
  logic              dmi_pwrite;
  logic [W_ADDR-1:0] dmi_paddr;
  logic [W_DATA-1:0] dmi_pwdata;
  logic [W_DATA-1:0] dmi_prdata;
  logic              dmi_pready;
  logic              dmi_pslverr;

  modport master (
    input  req_valid, req_op, req_addr, req_data, rsp_ready, err_clr,
           dmi_prdata, dmi_pready, dmi_pslverr,
    output req_ready, rsp_valid, rsp_op, rsp_data, err_sticky,
           dmi_psel, dmi_penable, dmi_pwrite, dmi_paddr, dmi_pwdata
  );

  modport slave (
    output req_valid, req_op, req_addr, req_data, rsp_ready, err_clr,
           dmi_prdata, dmi_pready, dmi_pslverr,
    input  req_ready, rsp_valid, rsp_op, rsp_data, err_sticky,
           dmi_psel, dmi_penable, dmi_pwrite, dmi_paddr, dmi_pwdata
  );
endinterface

// File: rtl/hazard3_dmi_apb_master.sv
// DTM-side DMI sequencer: runs one DMI request at a time as an APB master transfer
// and returns a DMI status/data response, keeping the sticky DMI error flag.
//
// state  | meaning
// IDLE   | ready for a request
// SETUP  | APB setup phase (psel=1, penable=0), one cycle
// ACCESS | APB access phase, waiting for pready
// RESP   | response held until rsp_ready
module hazard3_dmi_apb_master #(
  parameter int W_ADDR = 8,
  parameter int W_DATA = 32
) (
  input logic                    clk,
  input logic                    rst,
  hazard3_dmi_apb_master_if.master bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;
  localparam logic [1:0] RSP_OK   = 2'd0;
  localparam logic [1:0] RSP_FAIL = 2'd2;

  state_t            state, state_nxt;
  logic              psel_q, psel_nxt;
  logic              penable_q, penable_nxt;
  logic              pwrite_q, pwrite_nxt;
  logic [W_ADDR-1:0] paddr_q, paddr_nxt;
  logic [W_DATA-1:0] pwdata_q, pwdata_nxt;
  logic              rsp_valid_q, rsp_valid_nxt;
  logic [1:0]        rsp_op_q, rsp_op_nxt;
  logic [W_DATA-1:0] rsp_data_q, rsp_data_nxt;
  logic              err_q, err_nxt;
  logic              accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_op_q    <= RSP_OK;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state       <= state_nxt;
      psel_q      <= psel_nxt;
      penable_q   <= penable_nxt;
      pwrite_q    <= pwrite_nxt;
      paddr_q     <= paddr_nxt;
      pwdata_q    <= pwdata_nxt;
      rsp_valid_q <= rsp_valid_nxt;
      rsp_op_q    <= rsp_op_nxt;
      rsp_data_q  <= rsp_data_nxt;
      err_q       <= err_nxt;
    end
  end

  assign accept = bus.req_valid && (state == IDLE);

  always_comb begin
    state_nxt     = state;
    psel_nxt      = psel_q;
    penable_nxt   = penable_q;
    pwrite_nxt    = pwrite_q;
    paddr_nxt     = paddr_q;
    pwdata_nxt    = pwdata_q;
    rsp_valid_nxt = rsp_valid_q;
    rsp_op_nxt    = rsp_op_q;
    rsp_data_nxt  = rsp_data_q;
    // Clear first so that a same-cycle set below takes priority.
    err_nxt       = bus.err_clr ? 1'b0 : err_q;

    case (state)
      IDLE: begin
        if (accept) begin
          if ((bus.req_op == OP_READ || bus.req_op == OP_WRITE) && !err_q) begin
            paddr_nxt   = bus.req_addr;
            pwdata_nxt  = bus.req_data;
            pwrite_nxt  = (bus.req_op == OP_WRITE);
            psel_nxt    = 1'b1;
            penable_nxt = 1'b0;
            state_nxt   = SETUP;
          end else begin
            rsp_valid_nxt = 1'b1;
            rsp_data_nxt  = '0;
            rsp_op_nxt    = (bus.req_op == OP_NOP) ? RSP_OK : RSP_FAIL;
            if (bus.req_op == 2'd3) err_nxt = 1'b1;
            state_nxt     = RESP;
          end
        end
      end
      SETUP: begin
        penable_nxt = 1'b1;
        state_nxt   = ACCESS;
      end
      ACCESS: begin
        if (bus.dmi_pready) begin
          psel_nxt      = 1'b0;
          penable_nxt   = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_op_nxt    = bus.dmi_pslverr ? RSP_FAIL : RSP_OK;
          rsp_data_nxt  = (!pwrite_q && !bus.dmi_pslverr) ? bus.dmi_prdata : '0;
          if (bus.dmi_pslverr) err_nxt = 1'b1;
          state_nxt     = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.req_ready   = (state == IDLE);
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_op      = rsp_op_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.err_sticky  = err_q;
  assign bus.dmi_psel    = psel_q;
  assign bus.dmi_penable = penable_q;
  assign bus.dmi_pwrite  = pwrite_q;
  assign bus.dmi_paddr   = paddr_q;
  assign bus.dmi_pwdata  = pwdata_q;

endmodule

// File: tb/tb_hazard3_dmi_apb_master.sv
// Directed bench for hazard3_dmi_apb_master: expected responses are queued when a request
// is issued and popped when the DUT presents a response; a small APB slave model answers.
module tb_hazard3_dmi_apb_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard3_dmi_apb_master_if #(.W_ADDR(8), .W_DATA(32)) bus ();

  hazard3_dmi_apb_master #(.W_ADDR(8), .W_DATA(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // APB slave model: slv_wait wait states, then pready with slv_rdata / slv_err.
  int          slv_wait  = 0;
  logic [31:0] slv_rdata = '0;
  logic        slv_err   = 1'b0;
  int          wcnt      = 0;
  int          setup_cnt = 0;

  assign bus.dmi_pready  = bus.dmi_psel && bus.dmi_penable && (wcnt == slv_wait);
  assign bus.dmi_prdata  = slv_rdata;
  assign bus.dmi_pslverr = bus.dmi_pready && slv_err;

  always @(posedge clk) begin
    if (bus.dmi_psel && bus.dmi_penable && (wcnt != slv_wait)) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (bus.dmi_psel && !bus.dmi_penable) setup_cnt <= setup_cnt + 1;
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents a request in the current cycle; returns one cycle after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [7:0] addr, input logic [31:0] data);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_data  = data;
    chk("req_ready_at_accept", bus.req_ready, 1'b1);
    tick();
    bus.req_valid = 1'b0;
  endtask

  // Waits (bounded) for rsp_valid, checks latency and the scoreboard, then handshakes.
  task automatic get_rsp(input string tag, input int exp_wait);
    int   waited;
    exp_t e;
    waited = 0;
    while (!bus.rsp_valid && waited < 20) begin
      tick();
      waited++;
    end
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 1'b1);
    chk({tag, "_latency"}, waited, exp_wait);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s_scoreboard: observed response expected none", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_rsp_op"}, bus.rsp_op, e.op);
      chk({tag, "_rsp_data"}, bus.rsp_data, e.data);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk({tag, "_rsp_done"}, bus.rsp_valid, 1'b0);
  endtask

  initial begin
    int s0;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'd0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b0;
    bus.err_clr   = 1'b0;

    // Reset state
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_req_ready", bus.req_ready, 1'b1);
    chk("rst_psel", bus.dmi_psel, 1'b0);
    chk("rst_penable", bus.dmi_penable, 1'b0);
    chk("rst_pwrite", bus.dmi_pwrite, 1'b0);
    chk("rst_paddr", bus.dmi_paddr, 32'h0);
    chk("rst_pwdata", bus.dmi_pwdata, 32'h0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_op", bus.rsp_op, 2'd0);
    chk("rst_rsp_data", bus.rsp_data, 32'h0);
    chk("rst_err", bus.err_sticky, 1'b0);

    // Zero-wait write
    tick();
    exp_q.push_back('{2'd0, 32'h0});
    send(2'd2, 8'h10, 32'hdeadbeef);
    chk("wr_c1_psel", bus.dmi_psel, 1'b1);
    chk("wr_c1_penable", bus.dmi_penable, 1'b0);
    chk("wr_c1_pwrite", bus.dmi_pwrite, 1'b1);
    chk("wr_c1_paddr", bus.dmi_paddr, 32'h10);
    chk("wr_c1_pwdata", bus.dmi_pwdata, 32'hdeadbeef);
    chk("wr_c1_req_ready", bus.req_ready, 1'b0);
    tick();
    chk("wr_c2_psel", bus.dmi_psel, 1'b1);
    chk("wr_c2_penable", bus.dmi_penable, 1'b1);
    chk("wr_c2_req_ready", bus.req_ready, 1'b0);
    tick();
    chk("wr_c3_psel", bus.dmi_psel, 1'b0);
    chk("wr_c3_penable", bus.dmi_penable, 1'b0);
    chk("wr_c3_req_ready", bus.req_ready, 1'b0);
    get_rsp("wr", 0);
    chk("wr_c4_req_ready", bus.req_ready, 1'b1);

    // Read with three wait states
    slv_wait = 3;
    slv_rdata = 32'h12345678;
    exp_q.push_back('{2'd0, 32'h12345678});
    send(2'd1, 8'h11, 32'h0badf00d);
    chk("rd_setup_psel", bus.dmi_psel, 1'b1);
    chk("rd_setup_penable", bus.dmi_penable, 1'b0);
    chk("rd_pwrite", bus.dmi_pwrite, 1'b0);
    chk("rd_pwdata_loaded", bus.dmi_pwdata, 32'h0badf00d);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rd_acc_penable", bus.dmi_penable, 1'b1);
      chk("rd_acc_psel", bus.dmi_psel, 1'b1);
      chk("rd_acc_paddr", bus.dmi_paddr, 32'h11);
      chk("rd_acc_rsp_valid", bus.rsp_valid, 1'b0);
    end
    tick();
    get_rsp("rd", 0);
    chk("rd_paddr_kept", bus.dmi_paddr, 32'h11);

    // Slave error, sticky blocking, clear
    slv_wait = 0;
    slv_err = 1'b1;
    exp_q.push_back('{2'd2, 32'h0});
    send(2'd2, 8'h20, 32'h1);
    get_rsp("slverr", 2);
    chk("slverr_sticky", bus.err_sticky, 1'b1);
    slv_err = 1'b0;
    s0 = setup_cnt;
    exp_q.push_back('{2'd2, 32'h0});
    send(2'd1, 8'h21, 32'h0);
    get_rsp("sticky_rd", 0);
    chk("sticky_rd_no_bus", setup_cnt, s0);
    chk("sticky_paddr_kept", bus.dmi_paddr, 32'h20);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    chk("errclr_sticky", bus.err_sticky, 1'b0);
    slv_rdata = 32'hcafef00d;
    exp_q.push_back('{2'd0, 32'hcafef00d});
    send(2'd1, 8'h22, 32'h0);
    get_rsp("clr_rd", 2);
    chk("clr_rd_bus", setup_cnt, s0 + 1);

    // Nop, then op 3 with a simultaneous clear (set wins)
    s0 = setup_cnt;
    exp_q.push_back('{2'd0, 32'h0});
    send(2'd0, 8'h23, 32'h5);
    get_rsp("nop", 0);
    chk("nop_sticky", bus.err_sticky, 1'b0);
    exp_q.push_back('{2'd2, 32'h0});
    bus.err_clr = 1'b1;
    send(2'd3, 8'h24, 32'h6);
    bus.err_clr = 1'b0;
    chk("op3_sticky", bus.err_sticky, 1'b1);
    get_rsp("op3", 0);
    chk("busless_no_bus", setup_cnt, s0);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;

    // Response backpressure with a new request pending
    slv_rdata = 32'ha5a5a5a5;
    exp_q.push_back('{2'd0, 32'ha5a5a5a5});
    send(2'd1, 8'h30, 32'h0);
    tick();
    tick();
    bus.req_valid = 1'b1;
    bus.req_op    = 2'd2;
    bus.req_addr  = 8'h31;
    bus.req_data  = 32'h00000055;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", bus.rsp_valid, 1'b1);
      chk("bp_rsp_data", bus.rsp_data, 32'ha5a5a5a5);
      chk("bp_req_ready", bus.req_ready, 1'b0);
      chk("bp_psel", bus.dmi_psel, 1'b0);
      tick();
    end
    get_rsp("bp", 0);
    chk("bp_after_req_ready", bus.req_ready, 1'b1);
    exp_q.push_back('{2'd0, 32'h0});
    tick();
    bus.req_valid = 1'b0;
    chk("bp_next_psel", bus.dmi_psel, 1'b1);
    chk("bp_next_paddr", bus.dmi_paddr, 32'h31);
    get_rsp("bp_next", 2);

    // Reset during ACCESS
    slv_wait = 5;
    send(2'd1, 8'h40, 32'h0);
    tick();
    chk("rstacc_penable", bus.dmi_penable, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstacc_psel", bus.dmi_psel, 1'b0);
    chk("rstacc_penable_lo", bus.dmi_penable, 1'b0);
    chk("rstacc_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rstacc_err", bus.err_sticky, 1'b0);
    chk("rstacc_req_ready", bus.req_ready, 1'b1);
    slv_wait = 0;
    exp_q.push_back('{2'd0, 32'h0});
    send(2'd2, 8'h41, 32'h77);
    chk("post_rst_paddr", bus.dmi_paddr, 32'h41);
    get_rsp("post_rst", 2);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
